hazard_ctrl: RTL

Parametrised hazard controller for the pipelined CPU, sitting beside the ID/EX pipeline registers. It replaces purely combinational stall logic with a sequenced controller. The controller provides:
- multi-cycle redirect flushes;
- counted load-use stalls;
- EX/MEM forwarding selects per read port;
- a scoreboard for one multi-cycle functional unit (mul/div).

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_if.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 53 +++++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller.
//   state_t        - controller state encoding (IDLE / FLUSH / LDSTALL)
//   FWD_*          - per-port forwarding select encodings
//   max_u          - helper for sizing the state down-counter
package hazard_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StFlush   = 2'd1;
  localparam state_t StLdStall = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// hazard_if: pipeline-status and hazard-control bundle between the CPU pipeline
// (master) and hazard_ctrl (slave).
//   pipeline -> ctrl : id_valid, id_rs, id_rs_used, ex_valid, ex_we, ex_is_load, ex_rd,
//                      mem_valid, mem_we, mem_rd, redirect, mc_start, mc_rd,
//                      mc_done, mc_done_rd
//   ctrl -> pipeline : stall_if, stall_id, bubble_ex, flush_ifid, fwd_sel, busy
interface hazard_if #(
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned AW     = 5
);
  logic                   id_valid;
  logic [NUM_RD*AW-1:0]   id_rs;
  logic [NUM_RD-1:0]      id_rs_used;
  logic                   ex_valid;
  logic                   ex_we;
  logic                   ex_is_load;
  logic [AW-1:0]          ex_rd;
  logic                   mem_valid;
  logic                   mem_we;
  logic [AW-1:0]          mem_rd;
  logic                   redirect;
  logic                   mc_start;
  logic [AW-1:0]          mc_rd;
  logic                   mc_done;
  logic [AW-1:0]          mc_done_rd;
  logic                   stall_if;
  logic                   stall_id;
  logic                   bubble_ex;
  logic                   flush_ifid;
  logic [NUM_RD*2-1:0]    fwd_sel;
  logic                   busy;

  modport master (
    output id_valid, id_rs, id_rs_used, ex_valid, ex_we, ex_is_load, ex_rd,
           mem_valid, mem_we, mem_rd, redirect, mc_start, mc_rd, mc_done, mc_done_rd,
    input  stall_if, stall_id, bubble_ex, flush_ifid, fwd_sel, busy
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, ex_valid, ex_we, ex_is_load, ex_rd,
           mem_valid, mem_we, mem_rd, redirect, mc_start, mc_rd, mc_done, mc_done_rd,
    output stall_if, stall_id, bubble_ex, flush_ifid, fwd_sel, busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pending-write bit per register for the multi-cycle unit.
//   clk, rst_n           clock, async active-low reset
//   mc_start, mc_rd      set request (ignored for register 0)
//   mc_done, mc_done_rd  clear request; a simultaneous set of the same bit wins
//   rs, rs_chk           per-port read addresses and "port really reads" qualifiers
//   rd_busy              some qualified read port targets a pending register
//   waw                  mc_start targets a register that is already pending
//   any                  scoreboard non-empty
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned AW     = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mc_start,
  input  logic [AW-1:0]        mc_rd,
  input  logic                 mc_done,
  input  logic [AW-1:0]        mc_done_rd,
  input  logic [NUM_RD*AW-1:0] rs,
  input  logic [NUM_RD-1:0]    rs_chk,
  output logic                 rd_busy,
  output logic                 waw,
  output logic                 any
);
  localparam int unsigned NumRegs = 2 ** AW;

  logic [NumRegs-1:0] sb_q, sb_d;

  // Clear first so that a same-cycle set of the same register survives.
  always_comb begin
    sb_d = sb_q;
    if (mc_done) sb_d[mc_done_rd] = 1'b0;
    if (mc_start && (mc_rd != '0)) sb_d[mc_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  always_comb begin
    rd_busy = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rs_chk[k] && sb_q[rs[k*AW +: AW]]) rd_busy = 1'b1;
    end
  end

  assign waw = mc_start && sb_q[mc_rd];
  assign any = |sb_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: sequenced hazard controller beside the ID/EX pipeline registers.
// Handles redirect flushes, counted load-use stalls, EX/MEM forwarding selects and a
// scoreboard for one multi-cycle unit.
//   clk, rst_n  clock, async active-low reset
//   bus         hazard_if slave: pipeline status in, stall/bubble/flush/fwd_sel/busy out
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned AW       = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned BR_FLUSH = 2,
  parameter bit          FWD_EN   = 1'b1
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave bus
);
  localparam int unsigned CntW = $clog2(max_u(LOAD_LAT, BR_FLUSH)) + 1;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NUM_RD-1:0] rd_chk, ex_hit, mem_hit;
  logic              sb_rd_busy, sb_waw, sb_any;
  logic              load_use, raw_stall, hold, flush;
  logic [NUM_RD*2-1:0] fwd;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [AW-1:0] rs;
    assign rs         = bus.id_rs[k*AW +: AW];
    assign rd_chk[k]  = bus.id_valid && bus.id_rs_used[k] && (rs != '0);
    assign ex_hit[k]  = rd_chk[k] && bus.ex_valid && bus.ex_we && (bus.ex_rd == rs);
    assign mem_hit[k] = rd_chk[k] && bus.mem_valid && bus.mem_we && (bus.mem_rd == rs);
  end

  hazard_scoreboard #(
    .AW     (AW),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .mc_start   (bus.mc_start),
    .mc_rd      (bus.mc_rd),
    .mc_done    (bus.mc_done),
    .mc_done_rd (bus.mc_done_rd),
    .rs         (bus.id_rs),
    .rs_chk     (rd_chk),
    .rd_busy    (sb_rd_busy),
    .waw        (sb_waw),
    .any        (sb_any)
  );

  assign load_use  = bus.ex_is_load && (|ex_hit);
  assign raw_stall = !FWD_EN && (|(ex_hit | mem_hit));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    hold    = 1'b0;
    if (bus.redirect) begin
      // Redirect overrides everything, including a load stall in progress.
      flush = 1'b1;
      if (BR_FLUSH > 1) begin
        state_d = StFlush;
        cnt_d   = CntW'(BR_FLUSH - 1);
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end else if (state_q == StFlush) begin
      flush = 1'b1;
      if (cnt_q <= CntW'(1)) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end else begin
      // Every remaining stall source drives identical outputs; only the load-use
      // sequencing needs state, and it advances even while the scoreboard stalls.
      hold = sb_rd_busy || sb_waw || load_use || (state_q == StLdStall) || raw_stall;
      if (load_use && (LOAD_LAT > 1)) begin
        state_d = StLdStall;
        cnt_d   = CntW'(LOAD_LAT - 1);
      end else if (state_q == StLdStall) begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fwd = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (FWD_EN && !hold && !flush) begin
        if (ex_hit[k] && !bus.ex_is_load) fwd[2*k +: 2] = FWD_EX;
        else if (mem_hit[k])              fwd[2*k +: 2] = FWD_MEM;
        else                              fwd[2*k +: 2] = FWD_RF;
      end
    end
  end

  // Outputs are forced low while reset is asserted, independent of inputs.
  assign bus.stall_if   = rst_n && hold;
  assign bus.stall_id   = rst_n && hold;
  assign bus.bubble_ex  = rst_n && (hold || flush);
  assign bus.flush_ifid = rst_n && flush;
  assign bus.fwd_sel    = rst_n ? fwd : '0;
  assign bus.busy       = rst_n && ((state_q != StIdle) || sb_any);

endmodule
